// File: rtl/miniscope_sequencer_if.sv
// Readout stream from the miniscope sequencer toward the DMB readout mux.
// Valid/ready handshake; the sequencer is the master.
interface miniscope_sequencer_if #(parameter int DW = 16);
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  modport master (output rd_valid, rd_data, rd_last, input  rd_ready);
  modport slave  (input  rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/miniscope_sequencer.sv
// Miniscope FIFO RAM address/readout controller: continuous circular write,
// triggered look-back readout streamed out through a valid/ready port.
module miniscope_sequencer #(
  parameter int RAM_ADRB  = 11,
  parameter int RAM_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2*RAM_WIDTH-1:0] mini_data,
  input  logic                   mini_wr_en,
  input  logic [4:0]             mini_tbins,
  input  logic [RAM_ADRB-1:0]    mini_offset,
  input  logic                   mini_trig,
  input  logic                   err_clr,
  output logic                   fifo_wen,
  output logic [RAM_ADRB-1:0]    fifo_wadr_mini,
  output logic [2*RAM_WIDTH-1:0] fifo_wdata_mini,
  output logic [RAM_ADRB-1:0]    fifo_radr_mini,
  input  logic [2*RAM_WIDTH-1:0] fifo_rdata_mini,
  input  logic [1:0]             parity_err_mini,
  output logic                   mini_busy,
  output logic [7:0]             drop_cnt,
  output logic                   parity_err_sticky,
  miniscope_sequencer_if.master  rd
);

  typedef enum logic [1:0] {IDLE, ARM, READ, DONE} state_t;

  state_t                 r_state;
  logic                   r_wen;
  logic [RAM_ADRB-1:0]    r_wadr;
  logic [2*RAM_WIDTH-1:0] r_wdata;
  logic [RAM_ADRB-1:0]    r_radr;
  logic [4:0]             r_n;
  logic [4:0]             r_k;
  logic                   r_rd_valid;
  logic                   r_rd_last;
  logic                   r_busy;
  logic [7:0]             r_drop;
  logic                   r_sticky;

  logic w_accept;
  logic w_step;

  assign w_accept = r_rd_valid & rd.rd_ready;
  // Look ahead by one on a non-final accept so the RAM's registered output
  // already holds the next word when radr advances: no bubble between words.
  assign w_step   = w_accept & ~r_rd_last;

  assign fifo_wen          = r_wen;
  assign fifo_wadr_mini    = r_wadr;
  assign fifo_wdata_mini   = r_wdata;
  assign fifo_radr_mini    = r_radr + {{(RAM_ADRB-1){1'b0}}, w_step};
  assign rd.rd_valid       = r_rd_valid;
  assign rd.rd_data        = fifo_rdata_mini;
  assign rd.rd_last        = r_rd_last;
  assign mini_busy         = r_busy;
  assign drop_cnt          = r_drop;
  assign parity_err_sticky = r_sticky;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wen      <= 1'b0;
      r_wadr     <= '0;
      r_wdata    <= '0;
      r_radr     <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= '0;
      r_sticky   <= 1'b0;
    end else begin
      r_wdata <= mini_data;
      r_wen   <= mini_wr_en;
      if (r_wen) r_wadr <= r_wadr + 1'b1;

      if (mini_trig && r_busy && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;

      // A parity error on an accepted word beats a coincident clear.
      if (w_accept && (|parity_err_mini)) r_sticky <= 1'b1;
      else if (err_clr)                   r_sticky <= 1'b0;

      case (r_state)
        IDLE: begin
          if (mini_trig && (mini_tbins != 5'd0)) begin
            r_radr  <= r_wadr - mini_offset;
            r_n     <= mini_tbins;
            r_busy  <= 1'b1;
            r_state <= ARM;
          end
        end
        ARM: begin
          r_rd_valid <= 1'b1;
          r_rd_last  <= (r_n == 5'd1);
          r_k        <= '0;
          r_state    <= READ;
        end
        READ: begin
          if (w_accept) begin
            if (r_rd_last) begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_state    <= DONE;
            end else begin
              r_radr    <= r_radr + 1'b1;
              r_k       <= r_k + 5'd1;
              r_rd_last <= ((r_k + 5'd2) == r_n);
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miniscope_sequencer.sv
// Randomized bench for miniscope_sequencer: a RAM model plus a sample-history
// reference that predicts every readout word from the write order alone.
module tb_miniscope_sequencer;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   mini_data = '0;
  logic          mini_wr_en = 1'b0;
  logic [4:0]    mini_tbins = '0;
  logic [AW-1:0] mini_offset = '0;
  logic          mini_trig = 1'b0;
  logic          err_clr = 1'b0;
  logic          fifo_wen;
  logic [AW-1:0] fifo_wadr_mini;
  logic [15:0]   fifo_wdata_mini;
  logic [AW-1:0] fifo_radr_mini;
  logic [15:0]   fifo_rdata_mini = '0;
  logic [1:0]    parity_err_mini = '0;
  logic          mini_busy;
  logic [7:0]    drop_cnt;
  logic          parity_err_sticky;

  miniscope_sequencer_if #(.DW(16)) rd_if ();

  miniscope_sequencer #(.RAM_ADRB(AW), .RAM_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .mini_data(mini_data), .mini_wr_en(mini_wr_en), .mini_tbins(mini_tbins),
    .mini_offset(mini_offset), .mini_trig(mini_trig), .err_clr(err_clr),
    .fifo_wen(fifo_wen), .fifo_wadr_mini(fifo_wadr_mini), .fifo_wdata_mini(fifo_wdata_mini),
    .fifo_radr_mini(fifo_radr_mini), .fifo_rdata_mini(fifo_rdata_mini),
    .parity_err_mini(parity_err_mini), .mini_busy(mini_busy), .drop_cnt(drop_cnt),
    .parity_err_sticky(parity_err_sticky), .rd(rd_if.master)
  );

  always #5 clock = ~clock;

  // Miniscope RAM: write port plus one-cycle registered read port.
  logic [15:0] ram [DEPTH];
  always @(posedge clock) begin
    if (fifo_wen) ram[fifo_wadr_mini] <= fifo_wdata_mini;
    fifo_rdata_mini <= ram[fifo_radr_mini];
  end

  int          checks = 0;
  int          errors = 0;
  int          bx = 0;
  bit          data_bx = 1'b1;
  logic [15:0] hist[$];    // samples in write order since reset
  int          m_drops = 0;
  bit          m_sticky = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_vld_exp = 1'b0;
  bit          m_last_exp = 1'b0;
  bit          m_accept = 1'b0;
  bit          m_rst_chk = 1'b0;
  logic [15:0] m_data_exp = '0;
  int          m_radr_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: inputs already set after the previous edge, outputs sampled at negedge.
  task automatic step();
    int w;
    bx++;
    mini_data = data_bx ? 16'(bx) : 16'($urandom);
    if (!reset_n) hist.delete();
    else if (mini_wr_en) hist.push_back(mini_data);
    @(negedge clock);
    if (reset_n) begin
      w = (hist.size() >= 2) ? hist.size() - 2 : 0;
      chk("wen",      {31'd0, fifo_wen}, {31'd0, hist.size() >= 2});
      chk("wadr",     {21'd0, fifo_wadr_mini}, w % DEPTH);
      chk("wdata",    {16'd0, fifo_wdata_mini}, (hist.size() >= 2) ? {16'd0, hist[hist.size()-2]} : 32'd0);
      chk("drop_cnt", {24'd0, drop_cnt}, m_drops);
      chk("sticky",   {31'd0, parity_err_sticky}, {31'd0, m_sticky});
      chk("busy",     {31'd0, mini_busy}, {31'd0, m_busy});
      chk("rd_valid", {31'd0, rd_if.rd_valid}, {31'd0, m_vld_exp});
      if (m_vld_exp) begin
        chk("rd_data", {16'd0, rd_if.rd_data}, {16'd0, m_data_exp});
        chk("rd_last", {31'd0, rd_if.rd_last}, {31'd0, m_last_exp});
        chk("radr",    {21'd0, fifo_radr_mini}, m_radr_exp);
      end
      if (m_rst_chk) begin
        chk("radr_rst", {21'd0, fifo_radr_mini}, 0);
        chk("last_rst", {31'd0, rd_if.rd_last}, 0);
      end
    end
    @(posedge clock);
    #1;
    if (!reset_n) begin
      m_drops  = 0;
      m_sticky = 1'b0;
    end else begin
      if (mini_trig && m_busy && m_drops < 255) m_drops++;
      if (m_accept && (|parity_err_mini)) m_sticky = 1'b1;
      else if (err_clr) m_sticky = 1'b0;
    end
  endtask

  task automatic idle(input int n, input bit rnd_clr);
    for (int i = 0; i < n; i++) begin
      mini_trig = 1'b0; parity_err_mini = '0;
      rd_if.rd_ready = 1'($urandom);
      err_clr = rnd_clr ? ($urandom_range(7) == 0) : 1'b0;
      m_busy = 1'b0; m_vld_exp = 1'b0; m_accept = 1'b0;
      step();
    end
    err_clr = 1'b0;
  endtask

  // Idle until the write pointer in the next cycle equals target.
  task automatic wait_w(input int target);
    bit found = 1'b0;
    for (int g = 0; g < 5000 && !found; g++) begin
      if (hist.size() >= 1 && ((hist.size() - 1) % DEPTH) == target) found = 1'b1;
      else idle(1, 1'b0);
    end
    chk("wait_wadr_timeout", {31'd0, found}, 1);
  endtask

  // rmode: 0 ready held, 1 random, 2 pattern 1,0,0. stall: leading ready=0 cycles
  // with a trigger every cycle. abort_at: reset after that many accepts (-1 none).
  task automatic readout(input int off, input int nt, input int rmode, input int stall,
                         input int trigp, input int par_idx, input bit clr_err, input int abort_at);
    int w, start, idx, g;
    logic [15:0] exp_q[$];
    bit rdy;
    w     = hist.size() - 1;
    start = w - off;
    for (int k = 0; k < nt; k++) exp_q.push_back(hist[start + k]);
    mini_trig = 1'b1; mini_tbins = 5'(nt); mini_offset = AW'(off);
    err_clr = 1'b0; parity_err_mini = '0; rd_if.rd_ready = 1'b0;
    m_busy = 1'b0; m_vld_exp = 1'b0; m_accept = 1'b0;
    step();
    // ARM cycle
    mini_trig = ($urandom_range(99) < trigp);
    mini_tbins = 5'($urandom); mini_offset = AW'($urandom);
    m_busy = 1'b1;
    step();
    idx = 0; g = 0;
    while (idx < nt && g < 2000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom);
        default: rdy = ((g % 3) == 0);
      endcase
      if (g < stall) rdy = 1'b0;
      rd_if.rd_ready  = rdy;
      mini_trig       = (g < stall) ? 1'b1 : ($urandom_range(99) < trigp);
      parity_err_mini = (rdy && idx == par_idx) ? 2'b01 : 2'b00;
      err_clr         = (clr_err && rdy && idx == par_idx) ? 1'b1
                      : ((trigp > 0) && ($urandom_range(15) == 0));
      m_vld_exp  = 1'b1;
      m_data_exp = exp_q[idx];
      m_last_exp = (idx == nt - 1);
      m_radr_exp = (start + idx + ((rdy && idx != nt - 1) ? 1 : 0) + 4 * DEPTH) % DEPTH;
      m_accept   = rdy;
      step();
      if (rdy) idx++;
      g++;
    end
    chk("readout_timeout", {31'd0, g >= 2000}, 0);
    parity_err_mini = '0; err_clr = 1'b0; m_accept = 1'b0; m_vld_exp = 1'b0;
    if (abort_at >= 0) begin
      reset_n = 1'b0; mini_trig = 1'b0; rd_if.rd_ready = 1'b0;
      step();
      reset_n = 1'b1; m_busy = 1'b0; m_rst_chk = 1'b1;
      step();
      m_rst_chk = 1'b0;
      return;
    end
    // DONE cycle, then idle with busy low
    mini_trig = ($urandom_range(99) < trigp);
    rd_if.rd_ready = 1'($urandom);
    step();
    mini_trig = 1'b0; m_busy = 1'b0;
    step();
    rd_if.rd_ready = 1'b0;
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    mini_wr_en = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    m_rst_chk = 1'b1;
    idle(1, 1'b0);
    m_rst_chk = 1'b0;

    // Basic look-back with data = bx counter
    wait_w(100);
    readout(8, 4, 0, 0, 0, -1, 1'b0, -1);
    // Wrap-around 2045..1 with ready held high
    wait_w(3);
    readout(6, 5, 0, 0, 0, -1, 1'b0, -1);
    data_bx = 1'b0;
    // Backpressure 1,0,0 pattern
    readout(20, 12, 2, 0, 0, -1, 1'b0, -1);
    // Parity set, clear, then error coincident with clear
    readout(10, 6, 1, 0, 0, 1, 1'b0, -1);
    err_clr = 1'b1; m_busy = 1'b0; m_vld_exp = 1'b0; m_accept = 1'b0; mini_trig = 1'b0;
    step();
    err_clr = 1'b0;
    idle(2, 1'b0);
    readout(10, 6, 0, 0, 0, 2, 1'b1, -1);
    idle(2, 1'b0);
    // Drop saturation, then a zero-tbins trigger
    readout(40, 31, 1, 320, 30, -1, 1'b0, -1);
    mini_trig = 1'b1; mini_tbins = 5'd0; m_busy = 1'b0; m_vld_exp = 1'b0; m_accept = 1'b0;
    step();
    mini_trig = 1'b0;
    idle(3, 1'b0);
    // Random readouts
    for (int r = 0; r < 8; r++) begin
      int nt, off;
      nt  = $urandom_range(31, 1);
      off = $urandom_range(64, nt);
      readout(off, nt, $urandom_range(2), 0, 20, $urandom_range(40) - 5, 1'($urandom), -1);
      idle($urandom_range(4), 1'b1);
    end
    // Reset mid-readout, then a normal readout
    readout(20, 10, 0, 0, 0, -1, 1'b0, 2);
    wait_w(40);
    readout(20, 10, 1, 0, 10, -1, 1'b0, -1);
    idle(3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/miniscope_sequencer.md
# miniscope_sequencer

Address and readout controller for the miniscope FIFO RAM. It continuously writes one 16-bit miniscope sample per bx into the 2048-deep circular RAM. On a readout trigger it looks back a programmable number of bx and streams a programmable number of tbins out through a valid/ready handshake toward the DMB readout mux. It sits directly upstream of the miniscope RAM: it drives the RAM write and read ports, consumes the RAM read data and parity-error flags, and presents them downstream.

## Interface
- RAM_ADRB, 11, RAM address width; the buffer is 2^RAM_ADRB deep
- RAM_WIDTH, 8, byte width; the data path is 2*RAM_WIDTH = 16 bits
- clock  in  1  TMB 40 MHz main clock (one clock; reset is synchronous and active-low)
- reset_n  in  1  synchronous active-low reset
- mini_data  in  16  miniscope sample for the current bx
- mini_wr_en  in  1  1 = continuous recording enabled
- mini_tbins  in  5  tbins per readout, 0..31
- mini_offset  in  RAM_ADRB  look-back distance in bx from the trigger
- mini_trig  in  1  readout request, single-cycle pulse
- err_clr  in  1  clears the sticky error flag
- fifo_wen  out  1  RAM write enable
- fifo_wadr_mini  out  RAM_ADRB  RAM write address
- fifo_wdata_mini  out  16  RAM write data
- fifo_radr_mini  out  RAM_ADRB  RAM read address (combinational, see Timing)
- fifo_rdata_mini  in  16  RAM read data, one-cycle registered latency
- parity_err_mini  in  2  RAM parity error per byte, aligned with fifo_rdata_mini
- rd_valid  out  1  output word valid
- rd_ready  in  1  downstream accepts the word
- rd_data  out  16  output word (equals fifo_rdata_mini)
- rd_last  out  1  marks the final tbin of the readout
- mini_busy  out  1  a readout is in progress
- drop_cnt  out  8  saturating count of triggers dropped while busy
- parity_err_sticky  out  1  sticky OR of parity errors seen on accepted words

## Operation
- **Write side**
  - fifo_wdata_mini is mini_data registered once.
  - fifo_wen is mini_wr_en registered once.
  - wadr (the fifo_wadr_mini register) increments modulo 2^RAM_ADRB in every cycle that fifo_wen = 1.
  - Writes continue during readout.
- **FSM states:** IDLE, ARM, READ, DONE.
  - **IDLE:** on mini_trig with mini_tbins != 0, latch the following, then go to ARM:
    - start = wadr - mini_offset, modulo 2^RAM_ADRB, using the wadr value in the trigger cycle
    - n = mini_tbins
  - **Trigger with mini_tbins = 0:** ignored; no state change, no drop counted.
  - **ARM:** radr = start, so the address is presented to the RAM. Go to READ.
  - **READ:**
    - rd_valid = 1; rd_data corresponds to radr.
    - On rd_valid & rd_ready: radr increments modulo 2^RAM_ADRB and the word count k increments.
    - rd_last = (k == n-1).
    - An accept with rd_last asserted goes to DONE.
  - **DONE:** lasts 1 cycle with mini_busy still 1, then IDLE.
- **Busy and drops**
  - mini_busy = 1 in ARM, READ and DONE.
  - mini_trig while mini_busy = 1 is dropped; drop_cnt increments and saturates at 255.
- **Parity:** on each accepted word, parity_err_sticky |= |parity_err_mini. err_clr clears the flag; if an error and err_clr arrive in the same cycle, the error wins.
- **Integrity limit:** data is valid only if the readout completes within 2^RAM_ADRB - mini_offset cycles of the trigger. mini_offset must be >= mini_tbins for the data to have been written before the trigger. Both are programming rules; the block does not check them.
- **Reset:** all registers clear, in any state including mid-readout. Reset values:
  - fifo_wen=0, fifo_wadr_mini=0, fifo_wdata_mini=0
  - radr=0, state=IDLE, rd_valid=0, rd_last=0
  - mini_busy=0, drop_cnt=0, parity_err_sticky=0
  - The downstream consumer must discard any partial readout.

## Timing
- **Write latency:** mini_data in cycle t is written at the address fifo_wadr_mini shows in cycle t+1.
- **Read address:** fifo_radr_mini = radr + (rd_valid & rd_ready & ~rd_last), so the RAM has already fetched the next word when radr advances. This gives zero-bubble throughput.
- **Trigger latency:** mini_trig at cycle t → ARM at t+1 → first rd_valid at t+2.
- **Throughput:** one word per cycle while rd_ready = 1.
- **Stall:** while rd_ready = 0, radr is held and rd_data stays stable (the RAM re-reads the same address).
- **End of readout:** last accept at cycle u → DONE at u+1 → mini_busy = 0 and a new trigger accepted at u+2.
- **Wrap-around:** start may exceed 2^RAM_ADRB - n. The read address wraps 2047 → 0 with no gap.

## Test plan
- **Basic look-back:** mini_data = bx counter, wen on, mini_offset=8, mini_tbins=4, trig when wadr=100 → 4 words from addresses 92,93,94,95 (data = writer bx values), rd_last on the 4th word, mini_busy low 2 cycles after the last accept.
- **Wrap:** trig at wadr=3, offset=6, tbins=5 → read addresses 2045, 2046, 2047, 0, 1; no bubble when rd_ready is held at 1.
- **Backpressure:** rd_ready toggled 1,0,0,1,… → rd_data held stable through stalls; exactly n words accepted, in order.
- **Drops:** 300 triggers issued while busy → drop_cnt = 255; a trigger with tbins=0 → no busy, drop_cnt unchanged.
- **Parity:** force parity_err_mini=2'b01 on the 2nd accepted word → parity_err_sticky=1 from the next cycle; err_clr → 0; err_clr coincident with an error → stays 1.
- **Reset mid-READ:** reset_n=0 after 2 of 10 words → next cycle: state IDLE, rd_valid=0, mini_busy=0, counters 0; a new trigger afterwards reads out normally.
